id_ex_pipe_reg: RTL and testbench

//  Parametrised, elastic ID->EX pipeline register for the RISC-V core. Clocked, with a

---
 rtl/id_ex_pipe_reg_if.sv | 49 ++++
 rtl/id_ex_pipe_reg.sv | 142 ++++++++++++++
 tb/tb_id_ex_pipe_reg.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_pipe_reg_if.sv
// ID->EX stage bundle: decode-side offer (in_*) and execute-side delivery (out_*) with valid/ready.
interface id_ex_pipe_reg_if #(
    parameter int XLEN = 32,
    parameter int RAW  = 5,
    parameter int WB_W = 2,
    parameter int M_W  = 3
);
    logic            in_valid;
    logic            in_ready;
    logic [WB_W-1:0] in_wb;
    logic [M_W-1:0]  in_m;
    logic [3:0]      in_ex;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_rdata1;
    logic [XLEN-1:0] in_rdata2;
    logic [XLEN-1:0] in_imm;
    logic [RAW-1:0]  in_rs1;
    logic [RAW-1:0]  in_rs2;
    logic [RAW-1:0]  in_rd;

    logic            out_valid;
    logic            out_ready;
    logic [WB_W-1:0] out_wb;
    logic [M_W-1:0]  out_m;
    logic            out_regdst;
    logic [1:0]      out_aluop;
    logic            out_alusrc;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_rdata1;
    logic [XLEN-1:0] out_rdata2;
    logic [XLEN-1:0] out_imm;
    logic [RAW-1:0]  out_rs1;
    logic [RAW-1:0]  out_rs2;
    logic [RAW-1:0]  out_rd;

    modport slave (
        input  in_valid, in_wb, in_m, in_ex, in_pc, in_rdata1, in_rdata2, in_imm,
               in_rs1, in_rs2, in_rd, out_ready,
        output in_ready, out_valid, out_wb, out_m, out_regdst, out_aluop, out_alusrc,
               out_pc, out_rdata1, out_rdata2, out_imm, out_rs1, out_rs2, out_rd
    );

    modport master (
        output in_valid, in_wb, in_m, in_ex, in_pc, in_rdata1, in_rdata2, in_imm,
               in_rs1, in_rs2, in_rd, out_ready,
        input  in_ready, out_valid, out_wb, out_m, out_regdst, out_aluop, out_alusrc,
               out_pc, out_rdata1, out_rdata2, out_imm, out_rs1, out_rs2, out_rd
    );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// ID->EX elastic register, 1-cycle latency; a 2-entry skid keeps in_ready a flop output, which
// drops only while both entries are held. Flush empties both entries; perf counters saturate.
module id_ex_pipe_reg #(
    parameter int XLEN  = 32,
    parameter int RAW   = 5,
    parameter int WB_W  = 2,
    parameter int M_W   = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             cnt_clr,
    id_ex_pipe_reg_if.slave  bus,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);
    typedef struct packed {
        logic [WB_W-1:0] wb;
        logic [M_W-1:0]  m;
        logic [3:0]      ex;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rdata1;
        logic [XLEN-1:0] rdata2;
        logic [XLEN-1:0] imm;
        logic [RAW-1:0]  rs1;
        logic [RAW-1:0]  rs2;
        logic [RAW-1:0]  rd;
    } entry_t;

    localparam logic [1:0] S_EMPTY = 2'b00;
    localparam logic [1:0] S_FULL1 = 2'b10;
    localparam logic [1:0] S_FULL2 = 2'b11;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    entry_t           in_ent;
    entry_t           main_q, main_d, skid_q, skid_d;
    logic             main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
    logic             in_ready_q, in_ready_d;
    logic [CNT_W-1:0] stall_q, stall_d, bubble_q, bubble_d;
    logic [1:0]       state;
    logic             accept, emit;

    assign in_ent = '{wb: bus.in_wb, m: bus.in_m, ex: bus.in_ex, pc: bus.in_pc,
                      rdata1: bus.in_rdata1, rdata2: bus.in_rdata2, imm: bus.in_imm,
                      rs1: bus.in_rs1, rs2: bus.in_rs2, rd: bus.in_rd};

    assign state  = {main_vld_q, skid_vld_q};
    assign accept = bus.in_valid && in_ready_q;
    assign emit   = main_vld_q && bus.out_ready;

    always_comb begin
        main_d     = main_q;
        skid_d     = skid_q;
        main_vld_d = main_vld_q;
        skid_vld_d = skid_vld_q;
        if (flush) begin
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else begin
            case (state)
                S_FULL1: begin
                    if (accept && emit) begin
                        main_d = in_ent;
                    end else if (accept) begin
                        skid_d     = in_ent;
                        skid_vld_d = 1'b1;
                    end else if (emit) begin
                        main_vld_d = 1'b0;
                    end
                end
                S_FULL2: begin
                    // in_ready is low here, so only the skid-to-main shift can happen
                    if (emit) begin
                        main_d     = skid_q;
                        skid_vld_d = 1'b0;
                    end
                end
                default: begin
                    if (accept) begin
                        main_d     = in_ent;
                        main_vld_d = 1'b1;
                    end
                end
            endcase
        end
        in_ready_d = !skid_vld_d;
    end

    always_comb begin
        stall_d  = stall_q;
        bubble_d = bubble_q;
        if (cnt_clr) begin
            stall_d  = '0;
            bubble_d = '0;
        end else begin
            if (main_vld_q && !bus.out_ready && stall_q != CNT_MAX) begin
                stall_d = stall_q + 1'b1;
            end
            if (!main_vld_q && bus.out_ready && bubble_q != CNT_MAX) begin
                bubble_d = bubble_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            in_ready_q <= 1'b0;
            stall_q    <= '0;
            bubble_q   <= '0;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
            in_ready_q <= in_ready_d;
            stall_q    <= stall_d;
            bubble_q   <= bubble_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = main_vld_q;
    assign bus.out_wb     = main_vld_q ? main_q.wb : '0;
    assign bus.out_m      = main_vld_q ? main_q.m : '0;
    assign bus.out_regdst = main_vld_q & main_q.ex[3];
    assign bus.out_aluop  = main_vld_q ? main_q.ex[2:1] : 2'b00;
    assign bus.out_alusrc = main_vld_q & main_q.ex[0];
    assign bus.out_pc     = main_q.pc;
    assign bus.out_rdata1 = main_q.rdata1;
    assign bus.out_rdata2 = main_q.rdata2;
    assign bus.out_imm    = main_q.imm;
    assign bus.out_rs1    = main_q.rs1;
    assign bus.out_rs2    = main_q.rs2;
    assign bus.out_rd     = main_q.rd;
    assign stall_cnt      = stall_q;
    assign bubble_cnt     = bubble_q;
endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: a depth-2 queue model with saturating counters is compared against
// the DUT on every falling edge; directed scenarios add hand-computed literal checks.
module tb_id_ex_pipe_reg;
    localparam int CNT_W = 4;
    localparam int SAT   = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [1:0]  wb;
        logic [2:0]  m;
        logic [3:0]  ex;
        logic [31:0] pc;
        logic [31:0] rdata1;
        logic [31:0] rdata2;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
    } ent_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             cnt_clr;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] bubble_cnt;

    id_ex_pipe_reg_if #(.XLEN(32), .RAW(5), .WB_W(2), .M_W(3)) bus ();

    id_ex_pipe_reg #(.XLEN(32), .RAW(5), .WB_W(2), .M_W(3), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .cnt_clr    (cnt_clr),
        .bus        (bus),
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
    );

    always #5 clk = ~clk;

    ent_t mq[$];
    bit   m_rdy = 1'b0;
    int   m_stall = 0;
    int   m_bubble = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(bit v, logic [31:0] pc, logic [3:0] ex, bit ordy, bit fl, bit clr);
        bus.in_valid  = v;
        bus.in_pc     = pc;
        bus.in_ex     = ex;
        bus.out_ready = ordy;
        flush         = fl;
        cnt_clr       = clr;
        bus.in_wb     = 2'($urandom);
        bus.in_m      = 3'($urandom);
        bus.in_rdata1 = $urandom;
        bus.in_rdata2 = $urandom;
        bus.in_imm    = $urandom;
        bus.in_rs1    = 5'($urandom);
        bus.in_rs2    = 5'($urandom);
        bus.in_rd     = 5'($urandom);
    endtask

    // FIFO view of the stage: up to two entries, ready whenever fewer than two are held
    task automatic model_step();
        bit   ov, acc, emt;
        ent_t e;
        if (!rst_n) return;
        ov = (mq.size() != 0);
        if (cnt_clr) begin
            m_stall  = 0;
            m_bubble = 0;
        end else begin
            if (ov && !bus.out_ready)  m_stall  = (m_stall  < SAT) ? m_stall + 1  : SAT;
            if (!ov && bus.out_ready)  m_bubble = (m_bubble < SAT) ? m_bubble + 1 : SAT;
        end
        acc = bus.in_valid && m_rdy;
        emt = ov && bus.out_ready;
        e = '{wb: bus.in_wb, m: bus.in_m, ex: bus.in_ex, pc: bus.in_pc,
              rdata1: bus.in_rdata1, rdata2: bus.in_rdata2, imm: bus.in_imm,
              rs1: bus.in_rs1, rs2: bus.in_rs2, rd: bus.in_rd};
        if (flush) begin
            mq.delete();
        end else begin
            if (emt) void'(mq.pop_front());
            if (acc) mq.push_back(e);
        end
        m_rdy = (mq.size() < 2);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic model_reset();
        mq.delete();
        m_rdy    = 1'b0;
        m_stall  = 0;
        m_bubble = 0;
    endtask

    always @(negedge clk) begin
        ent_t e;
        bit   ov;
        ov = (mq.size() != 0);
        e  = ov ? mq[0] : '0;
        chk("out_valid",  32'(bus.out_valid),  32'(ov));
        chk("in_ready",   32'(bus.in_ready),   32'(m_rdy));
        chk("out_wb",     32'(bus.out_wb),     32'(e.wb));
        chk("out_m",      32'(bus.out_m),      32'(e.m));
        chk("out_regdst", 32'(bus.out_regdst), 32'(e.ex[3]));
        chk("out_aluop",  32'(bus.out_aluop),  32'(e.ex[2:1]));
        chk("out_alusrc", 32'(bus.out_alusrc), 32'(e.ex[0]));
        chk("stall_cnt",  32'(stall_cnt),      32'(m_stall));
        chk("bubble_cnt", 32'(bubble_cnt),     32'(m_bubble));
        if (ov) begin
            chk("out_pc",     bus.out_pc,             e.pc);
            chk("out_rdata1", bus.out_rdata1,         e.rdata1);
            chk("out_rdata2", bus.out_rdata2,         e.rdata2);
            chk("out_imm",    bus.out_imm,            e.imm);
            chk("out_rs1",    32'(bus.out_rs1),       32'(e.rs1));
            chk("out_rs2",    32'(bus.out_rs2),       32'(e.rs2));
            chk("out_rd",     32'(bus.out_rd),        32'(e.rd));
        end
    end

    initial begin
        rst_n = 1'b0;
        drive(0, 32'h0, 4'h0, 1, 0, 0);
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        cyc();
        chk("ready after release", 32'(bus.in_ready), 32'd1);

        // reset taken while both entries are held
        drive(0, 32'h0, 4'h0, 1, 1, 0); cyc();
        drive(1, 32'h10, 4'h0, 0, 0, 0); cyc();
        drive(1, 32'h14, 4'h0, 0, 0, 0); cyc();
        chk("full2 in_ready", 32'(bus.in_ready), 32'd0);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst in_ready",  32'(bus.in_ready),  32'd0);
        chk("rst out_wb",    32'(bus.out_wb),    32'd0);
        chk("rst stall_cnt", 32'(stall_cnt),     32'd0);
        drive(0, 32'h0, 4'h0, 1, 0, 0);
        cyc(); cyc();
        chk("rst held in_ready", 32'(bus.in_ready), 32'd0);
        rst_n = 1'b1;
        cyc();
        chk("post-rst in_ready", 32'(bus.in_ready), 32'd1);

        // streaming
        drive(0, 32'h0, 4'h0, 1, 1, 0); cyc();
        for (int i = 0; i < 8; i++) begin
            drive(1, 32'(32'h100 + 4 * i), 4'h0, 1, 0, 0);
            cyc();
            chk("stream pc",    bus.out_pc, 32'(32'h100 + 4 * i));
            chk("stream valid", 32'(bus.out_valid), 32'd1);
            chk("stream ready", 32'(bus.in_ready),  32'd1);
        end

        // backpressure
        drive(0, 32'h0, 4'h0, 0, 1, 1); cyc();
        drive(1, 32'h200, 4'h0, 0, 0, 0); cyc();
        drive(1, 32'h204, 4'h0, 0, 0, 0); cyc();
        drive(1, 32'h208, 4'h0, 0, 0, 0); cyc();
        chk("bp in_ready", 32'(bus.in_ready), 32'd0);
        cyc();
        chk("bp stall_cnt", 32'(stall_cnt), 32'd3);
        chk("bp head pc",   bus.out_pc,     32'h200);
        drive(0, 32'h0, 4'h0, 1, 0, 0); cyc();
        chk("bp second pc", bus.out_pc, 32'h204);
        cyc();
        chk("bp drained", 32'(bus.out_valid), 32'd0);

        // flush while both entries held and a third is offered
        drive(0, 32'h0, 4'h0, 1, 1, 0); cyc();
        drive(1, 32'h300, 4'hF, 0, 0, 0); bus.in_wb = 2'b11; bus.in_m = 3'b111; cyc();
        drive(1, 32'h304, 4'hF, 0, 0, 0); bus.in_wb = 2'b11; bus.in_m = 3'b111; cyc();
        chk("pre-flush out_wb", 32'(bus.out_wb), 32'd3);
        drive(1, 32'h308, 4'hF, 0, 1, 0); bus.in_wb = 2'b11; bus.in_m = 3'b111; cyc();
        chk("flush out_valid", 32'(bus.out_valid), 32'd0);
        chk("flush out_wb",    32'(bus.out_wb),    32'd0);
        chk("flush out_m",     32'(bus.out_m),     32'd0);
        chk("flush out_aluop", 32'(bus.out_aluop), 32'd0);
        drive(0, 32'h0, 4'hF, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("flush no ghost", 32'(bus.out_valid), 32'd0);
        end

        // ex field decode and bubble gating
        drive(1, 32'h400, 4'b1011, 1, 0, 0); cyc();
        chk("dec regdst", 32'(bus.out_regdst), 32'd1);
        chk("dec aluop",  32'(bus.out_aluop),  32'd1);
        chk("dec alusrc", 32'(bus.out_alusrc), 32'd1);
        drive(0, 32'h404, 4'b1111, 1, 0, 0); cyc();
        chk("bub valid",  32'(bus.out_valid),  32'd0);
        chk("bub regdst", 32'(bus.out_regdst), 32'd0);
        chk("bub aluop",  32'(bus.out_aluop),  32'd0);
        chk("bub alusrc", 32'(bus.out_alusrc), 32'd0);

        // counter saturation and clear priority
        drive(0, 32'h0, 4'h0, 0, 1, 1); cyc();
        drive(1, 32'h500, 4'h0, 0, 0, 0); cyc();
        drive(0, 32'h0, 4'h0, 0, 0, 0);
        repeat (20) cyc();
        chk("sat stall_cnt", 32'(stall_cnt), 32'd15);
        drive(0, 32'h0, 4'h0, 0, 0, 1); cyc();
        chk("clr stall_cnt", 32'(stall_cnt), 32'd0);
        drive(0, 32'h0, 4'h0, 0, 0, 0); cyc();
        chk("post-clr stall_cnt", 32'(stall_cnt), 32'd1);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(0, 3) != 0, $urandom, 4'($urandom),
                  $urandom_range(0, 9) < 6, $urandom_range(0, 39) == 0,
                  $urandom_range(0, 59) == 0);
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
